// File: rtl/drain_monitor_seq.sv
//==============================================================================
// Module   : drain_monitor_seq
// Purpose  : Watches the OR-tree "any lane active" bit and declares the NoC
//            slice drained after QUIET_CYCLES idle samples, or timed out.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module drain_monitor_seq #(
    parameter int QUIET_CYCLES   = 4,
    parameter int TIMEOUT_CYCLES = 16,
    parameter int QW             = $clog2(QUIET_CYCLES + 1),
    parameter int TW             = $clog2(TIMEOUT_CYCLES + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_en,
    input  logic          i_valid,
    input  logic          i_data_bus,
    input  logic          i_drain_req,
    input  logic          i_drain_ack,
    output logic          o_draining,
    output logic          o_drained,
    output logic          o_timeout,
    output logic [QW-1:0] o_quiet_cnt
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_DRAIN   = 2'd1,
        S_DONE    = 2'd2,
        S_TIMEOUT = 2'd3
    } state_t;

    localparam logic [QW-1:0] c_quiet_max = QW'(QUIET_CYCLES);
    localparam logic [TW-1:0] c_tmo_max   = TW'(TIMEOUT_CYCLES);

    state_t        r_state;
    logic [QW-1:0] r_quiet;
    logic [TW-1:0] r_tmo;

    state_t        w_state_nxt;
    logic [QW-1:0] w_quiet_nxt;
    logic [TW-1:0] w_tmo_nxt;
    logic [QW-1:0] w_quiet_inc;
    logic [TW-1:0] w_tmo_inc;
    logic          w_idle_sample;

    // An invalid sample is treated as busy so a stalled tree never looks drained.
    assign w_idle_sample = i_valid & ~i_data_bus;
    assign w_quiet_inc   = (r_quiet == c_quiet_max) ? r_quiet : r_quiet + QW'(1);
    assign w_tmo_inc     = (r_tmo == c_tmo_max) ? r_tmo : r_tmo + TW'(1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_quiet <= '0;
            r_tmo   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_quiet <= w_quiet_nxt;
            r_tmo   <= w_tmo_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_quiet_nxt = r_quiet;
        w_tmo_nxt   = r_tmo;
        if (i_en) begin
            case (r_state)
                S_IDLE: begin
                    if (i_drain_req) begin
                        w_state_nxt = S_DRAIN;
                        w_quiet_nxt = '0;
                        w_tmo_nxt   = '0;
                    end
                end
                S_DRAIN: begin
                    w_tmo_nxt   = w_tmo_inc;
                    w_quiet_nxt = w_idle_sample ? w_quiet_inc : '0;
                    // Quiet completion takes priority over a coincident timeout.
                    if (w_idle_sample && (w_quiet_inc == c_quiet_max)) begin
                        w_state_nxt = S_DONE;
                    end else if (w_tmo_inc == c_tmo_max) begin
                        w_state_nxt = S_TIMEOUT;
                    end
                end
                S_DONE, S_TIMEOUT: begin
                    if (i_drain_ack) begin
                        w_state_nxt = S_IDLE;
                        w_quiet_nxt = '0;
                        w_tmo_nxt   = '0;
                    end
                end
                default: begin
                    w_state_nxt = S_IDLE;
                    w_quiet_nxt = '0;
                    w_tmo_nxt   = '0;
                end
            endcase
        end
    end

    assign o_draining  = (r_state == S_DRAIN);
    assign o_drained   = (r_state == S_DONE);
    assign o_timeout   = (r_state == S_TIMEOUT);
    assign o_quiet_cnt = r_quiet;

endmodule

`default_nettype wire

// File: tb/tb_drain_monitor_seq.sv
//==============================================================================
// Module   : tb_drain_monitor_seq
// Purpose  : Self-checking bench for drain_monitor_seq (default and T=8 builds).
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_drain_monitor_seq;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic en = 1'b1, valid = 1'b0, data = 1'b0, req = 1'b0, ack = 1'b0;

    logic       d0_draining, d0_drained, d0_timeout;
    logic [2:0] d0_quiet;
    logic       d1_draining, d1_drained, d1_timeout;
    logic [2:0] d1_quiet;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    drain_monitor_seq #(.QUIET_CYCLES(4), .TIMEOUT_CYCLES(16)) dut0 (
        .clk(clk), .rst(rst), .i_en(en), .i_valid(valid), .i_data_bus(data),
        .i_drain_req(req), .i_drain_ack(ack),
        .o_draining(d0_draining), .o_drained(d0_drained),
        .o_timeout(d0_timeout), .o_quiet_cnt(d0_quiet)
    );

    drain_monitor_seq #(.QUIET_CYCLES(4), .TIMEOUT_CYCLES(8)) dut1 (
        .clk(clk), .rst(rst), .i_en(en), .i_valid(valid), .i_data_bus(data),
        .i_drain_req(req), .i_drain_ack(ack),
        .o_draining(d1_draining), .o_drained(d1_drained),
        .o_timeout(d1_timeout), .o_quiet_cnt(d1_quiet)
    );

    wire [5:0] obs [2];
    assign obs[0] = {d0_draining, d0_drained, d0_timeout, d0_quiet};
    assign obs[1] = {d1_draining, d1_drained, d1_timeout, d1_quiet};

    // Reference model: mode 0=idle 1=draining 2=drained 3=timed out;
    // run = consecutive idle samples so far, taken = samples since the request.
    int mode [2];
    int run [2];
    int taken [2];
    int tmo_lim [2] = '{16, 8};

    function automatic logic [5:0] model_vec(int k);
        return {mode[k] == 1, mode[k] == 2, mode[k] == 3, 3'(run[k])};
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            mode[k] = 0; run[k] = 0; taken[k] = 0;
        end
    endtask

    task automatic model_edge();
        if (rst) begin
            model_reset();
        end else if (en) begin
            for (int k = 0; k < 2; k++) begin
                if (mode[k] == 0) begin
                    if (req) begin mode[k] = 1; run[k] = 0; taken[k] = 0; end
                end else if (mode[k] == 1) begin
                    taken[k] += 1;
                    run[k] = (valid && !data) ? run[k] + 1 : 0;
                    if (run[k] >= 4)               mode[k] = 2;
                    else if (taken[k] >= tmo_lim[k]) mode[k] = 3;
                end else if (ack) begin
                    mode[k] = 0; run[k] = 0; taken[k] = 0;
                end
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic drive(input logic e, input logic v, input logic d,
                         input logic rq, input logic ak);
        en = e; valid = v; data = d; req = rq; ack = ak;
    endtask

    task automatic start_drain();
        drive(1, 1, 0, 1, 0);
        tick();
        req = 1'b0;
    endtask

    task automatic finish_ack();
        drive(1, 1, 0, 0, 1);
        tick();
        ack = 1'b0;
        for (int k = 0; k < 2; k++) begin
            checks++;
            if (obs[k] !== 6'b0) begin
                errors++;
                $display("FAIL ack_to_idle dut%0d: got %b want %b", k, obs[k], 6'b0);
            end
        end
    endtask

    task automatic test_reset();
        drive(1, 0, 0, 0, 0);
        rst = 1'b1;
        model_reset();
        tick(); tick();
        rst = 1'b0;
        tick();
        for (int k = 0; k < 2; k++) begin
            checks++;
            if (obs[k] !== 6'b0) begin
                errors++;
                $display("FAIL reset dut%0d: got %b want %b", k, obs[k], 6'b0);
            end
        end
    endtask

    task automatic test_quiet_drain();
        logic [5:0] want;
        start_drain();
        checks++;
        if (obs[0] !== 6'b100_000) begin
            errors++;
            $display("FAIL quiet_drain_start: got %b want %b", obs[0], 6'b100_000);
        end
        for (int s = 1; s <= 4; s++) begin
            tick();
            want = (s < 4) ? {3'b100, 3'(s)} : 6'b010_100;
            checks++;
            if (obs[0] !== want) begin
                errors++;
                $display("FAIL quiet_drain sample %0d: got %b want %b", s, obs[0], want);
            end
        end
        finish_ack();
    endtask

    task automatic test_pattern();
        logic [6:0] busy_pat = 7'b0000100;
        int exp_q [7] = '{1, 2, 0, 1, 2, 3, 4};
        logic [5:0] want;
        start_drain();
        for (int s = 0; s < 7; s++) begin
            data = busy_pat[s];
            tick();
            want = {s < 6, s == 6, 1'b0, 3'(exp_q[s])};
            checks++;
            if (obs[0] !== want || obs[1] !== model_vec(1)) begin
                errors++;
                $display("FAIL pattern sample %0d: got %b/%b want %b/%b",
                         s + 1, obs[0], obs[1], want, model_vec(1));
            end
        end
        finish_ack();
    endtask

    task automatic test_timeout();
        start_drain();
        data = 1'b1;
        for (int s = 1; s <= 16; s++) begin
            tick();
            checks++;
            if (obs[0] !== model_vec(0) || obs[1] !== model_vec(1)) begin
                errors++;
                $display("FAIL timeout sample %0d: got %b/%b want %b/%b",
                         s, obs[0], obs[1], model_vec(0), model_vec(1));
            end
        end
        checks++;
        if (obs[0] !== 6'b001_000) begin
            errors++;
            $display("FAIL timeout_final: got %b want %b", obs[0], 6'b001_000);
        end
        finish_ack();
    endtask

    task automatic test_coincide();
        start_drain();
        for (int s = 1; s <= 8; s++) begin
            data = (s <= 4);
            tick();
        end
        checks++;
        if (obs[1] !== 6'b010_100) begin
            errors++;
            $display("FAIL coincide dut1: got %b want %b", obs[1], 6'b010_100);
        end
        finish_ack();
    endtask

    task automatic test_invalid_busy();
        start_drain();
        for (int s = 1; s <= 7; s++) begin
            valid = (s > 3);
            data  = 1'b0;
            tick();
            checks++;
            if (obs[0] !== model_vec(0) || d0_drained !== (s == 7)) begin
                errors++;
                $display("FAIL invalid_busy sample %0d: got %b want %b drained_want %0d",
                         s, obs[0], model_vec(0), s == 7);
            end
        end
        finish_ack();
    endtask

    task automatic test_enable_hold();
        start_drain();
        tick(); tick();
        for (int c = 0; c < 5; c++) begin
            drive(0, 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
            tick();
            checks++;
            if (obs[0] !== 6'b100_010) begin
                errors++;
                $display("FAIL enable_hold cycle %0d: got %b want %b", c, obs[0], 6'b100_010);
            end
        end
        drive(1, 1, 0, 0, 0);
        tick(); tick();
        checks++;
        if (obs[0] !== 6'b010_100) begin
            errors++;
            $display("FAIL enable_resume: got %b want %b", obs[0], 6'b010_100);
        end
        finish_ack();
    endtask

    task automatic test_reset_mid();
        start_drain();
        tick(); tick();
        #3;
        rst = 1'b1;
        model_reset();
        #1;
        for (int k = 0; k < 2; k++) begin
            checks++;
            if (obs[k] !== 6'b0) begin
                errors++;
                $display("FAIL reset_mid dut%0d: got %b want %b", k, obs[k], 6'b0);
            end
        end
        #1;
        rst = 1'b0;
        tick();
    endtask

    task automatic test_req_ack();
        start_drain();
        tick(); tick(); tick(); tick();
        drive(1, 1, 0, 1, 0);
        tick();
        checks++;
        if (obs[0] !== 6'b010_100) begin
            errors++;
            $display("FAIL req_in_done: got %b want %b", obs[0], 6'b010_100);
        end
        drive(1, 1, 0, 1, 1);
        tick();
        checks++;
        if (obs[0] !== 6'b0) begin
            errors++;
            $display("FAIL req_ack_together: got %b want %b", obs[0], 6'b0);
        end
        drive(1, 1, 0, 0, 0);
        tick();
        checks++;
        if (obs[0] !== 6'b0) begin
            errors++;
            $display("FAIL req_not_latched: got %b want %b", obs[0], 6'b0);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 600; i++) begin
            rst = ($urandom_range(0, 149) == 0);
            drive(($urandom_range(0, 7) != 0), ($urandom_range(0, 4) != 0),
                  ($urandom_range(0, 3) == 0), ($urandom_range(0, 2) == 0),
                  ($urandom_range(0, 3) == 0));
            tick();
            for (int k = 0; k < 2; k++) begin
                checks++;
                if (obs[k] !== model_vec(k)) begin
                    errors++;
                    $display("FAIL random cycle %0d dut%0d: got %b want %b",
                             i, k, obs[k], model_vec(k));
                end
            end
        end
        rst = 1'b0;
    endtask

    initial begin
        model_reset();
        test_reset();
        test_quiet_drain();
        test_pattern();
        test_timeout();
        test_coincide();
        test_invalid_busy();
        test_enable_hold();
        test_reset_mid();
        test_req_ack();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
